// File: rtl/sparse_chunk_encoder_pkg.sv
// Shared sizing, byte-lane types and FSM states for the sparse chunk encoder.
// BUS_SIZE and MEM_SIZE are powers of two so a packed index splits cleanly into {beat, lane}.
package sparse_chunk_encoder_pkg;

    localparam int BUS_SIZE       = 4;
    localparam int MEM_SIZE       = 16;
    localparam int WR_DAT_CYC_NUM = MEM_SIZE / BUS_SIZE;

    localparam int CNT_W     = (WR_DAT_CYC_NUM > 1) ? $clog2(WR_DAT_CYC_NUM) : 1;
    localparam int LANE_W    = (BUS_SIZE > 1) ? $clog2(BUS_SIZE) : 1;
    localparam int MEM_IDX_W = $clog2(MEM_SIZE);
    localparam int NZ_W      = $clog2(MEM_SIZE) + 1;
    localparam int PC_W      = $clog2(BUS_SIZE) + 1;

    typedef logic [BUS_SIZE-1:0][7:0] lane_t;
    typedef logic [BUS_SIZE-1:0]      map_t;
    typedef logic [CNT_W-1:0]         cnt_t;
    typedef logic [NZ_W-1:0]          nz_t;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

endpackage

// File: rtl/sparse_beat_compactor.sv
// One dense beat -> non-zero map, left-packed non-zero bytes and their count.
// Purely combinational, no latency, no flow control.
module sparse_beat_compactor
    import sparse_chunk_encoder_pkg::*;
(
    input  lane_t             dat,
    output map_t              map,
    output lane_t             pk_dat,
    output logic [PC_W-1:0]   pop
);

    logic [PC_W-1:0] run;

    // run is the prefix count of non-zero bytes below lane b, i.e. its packed slot
    always_comb begin
        run    = '0;
        map    = '0;
        pk_dat = '0;
        for (int b = 0; b < BUS_SIZE; b++) begin
            map[b] = (dat[b] != 8'h00);
            if (map[b]) begin
                pk_dat[run[LANE_W-1:0]] = dat[b];
                run = run + PC_W'(1);
            end
        end
        pop = run;
    end

endmodule

// File: rtl/sparse_chunk_encoder.sv
// Collects a dense chunk, then replays it as sparse map + packed non-zero write beats.
// First write beat one cycle after the last accepted dense beat; dense_ready_o is low while emitting.
module sparse_chunk_encoder
    import sparse_chunk_encoder_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  lane_t       dense_dat_i,
    input  logic        dense_valid_i,
    output logic        dense_ready_o,
    input  logic        dst_sel_i,
    output map_t        sparsemap_o,
    output lane_t       nonzero_data_o,
    output logic        wr_valid_o,
    output cnt_t        wr_count_o,
    output logic        wr_sel_o,
    output logic        chunk_done_o,
    output nz_t         nz_count_o
);

    localparam cnt_t LAST_BEAT = cnt_t'(WR_DAT_CYC_NUM - 1);

    state_t                          state, state_nxt;
    cnt_t                            beat_cnt, beat_nxt;
    nz_t                             nz_ptr, nz_nxt;
    logic                            sel_nxt;
    map_t [WR_DAT_CYC_NUM-1:0]       map_mem, map_nxt;
    logic [MEM_SIZE-1:0][7:0]        pk_mem, pk_nxt;

    map_t                            beat_map;
    lane_t                           beat_pk;
    logic [PC_W-1:0]                 beat_pop;

    logic                            vld_nxt, done_nxt;
    cnt_t                            cnt_nxt;
    map_t                            smap_nxt;
    lane_t                           dat_nxt;
    nz_t                             off;
    logic [MEM_IDX_W-1:0]            rd_idx;
    logic                            accept;

    assign dense_ready_o = (state == COLLECT);
    assign accept        = dense_valid_i && dense_ready_o;
    assign nz_count_o    = nz_ptr;

    sparse_beat_compactor u_compactor (
        .dat    (dense_dat_i),
        .map    (beat_map),
        .pk_dat (beat_pk),
        .pop    (beat_pop)
    );

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat_cnt;
        nz_nxt    = nz_ptr;
        sel_nxt   = wr_sel_o;
        map_nxt   = map_mem;
        pk_nxt    = pk_mem;
        vld_nxt   = 1'b0;
        cnt_nxt   = '0;
        done_nxt  = 1'b0;
        smap_nxt  = '0;
        dat_nxt   = '0;
        off       = '0;
        rd_idx    = '0;

        case (state)
            COLLECT: begin
                if (accept) begin
                    map_nxt[beat_cnt] = beat_map;
                    // each storage slot picks its byte from the packed beat when it falls in [nz_ptr, nz_ptr+pop)
                    for (int m = 0; m < MEM_SIZE; m++) begin
                        off = nz_t'(m) - nz_ptr;
                        if ((nz_t'(m) >= nz_ptr) && (off < nz_t'(beat_pop)))
                            pk_nxt[m] = beat_pk[off[LANE_W-1:0]];
                    end
                    nz_nxt = nz_ptr + nz_t'(beat_pop);
                    if (beat_cnt == '0)
                        sel_nxt = dst_sel_i;
                    if (beat_cnt == LAST_BEAT) begin
                        beat_nxt  = '0;
                        state_nxt = EMIT;
                        vld_nxt   = 1'b1;
                        done_nxt  = (LAST_BEAT == '0);
                    end else begin
                        beat_nxt = beat_cnt + cnt_t'(1);
                    end
                end
            end
            EMIT: begin
                if (wr_count_o == LAST_BEAT) begin
                    state_nxt = COLLECT;
                    nz_nxt    = '0;
                end else begin
                    vld_nxt  = 1'b1;
                    cnt_nxt  = wr_count_o + cnt_t'(1);
                    done_nxt = (cnt_nxt == LAST_BEAT);
                end
            end
            default: state_nxt = COLLECT;
        endcase

        // output beat is built from next-state storage so beat 0 already includes the final dense beat
        if (vld_nxt) begin
            smap_nxt = map_nxt[cnt_nxt];
            for (int b = 0; b < BUS_SIZE; b++) begin
                rd_idx = {cnt_nxt, LANE_W'(b)};
                if ({1'b0, rd_idx} < nz_nxt)
                    dat_nxt[b] = pk_nxt[rd_idx];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= COLLECT;
            beat_cnt       <= '0;
            nz_ptr         <= '0;
            map_mem        <= '0;
            pk_mem         <= '0;
            wr_sel_o       <= 1'b0;
            wr_valid_o     <= 1'b0;
            wr_count_o     <= '0;
            chunk_done_o   <= 1'b0;
            sparsemap_o    <= '0;
            nonzero_data_o <= '0;
        end else begin
            state          <= state_nxt;
            beat_cnt       <= beat_nxt;
            nz_ptr         <= nz_nxt;
            map_mem        <= map_nxt;
            pk_mem         <= pk_nxt;
            wr_sel_o       <= sel_nxt;
            wr_valid_o     <= vld_nxt;
            wr_count_o     <= cnt_nxt;
            chunk_done_o   <= done_nxt;
            sparsemap_o    <= smap_nxt;
            nonzero_data_o <= dat_nxt;
        end
    end

endmodule

// File: tb/tb_sparse_chunk_encoder.sv
// Directed bench for sparse_chunk_encoder: chunk patterns, valid gaps, resets mid-collect and mid-emit.
module tb_sparse_chunk_encoder;
    import sparse_chunk_encoder_pkg::*;

    logic  clk = 1'b0;
    logic  rst;
    lane_t dense_dat;
    logic  dense_valid;
    logic  dense_ready;
    logic  dst_sel;
    map_t  sparsemap;
    lane_t nonzero_data;
    logic  wr_valid;
    cnt_t  wr_count;
    logic  wr_sel;
    logic  chunk_done;
    nz_t   nz_count;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] chunk   [MEM_SIZE];
    logic [7:0] exp_pk  [MEM_SIZE];
    map_t       exp_map [WR_DAT_CYC_NUM];
    int         exp_nz;

    sparse_chunk_encoder dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .dense_dat_i    (dense_dat),
        .dense_valid_i  (dense_valid),
        .dense_ready_o  (dense_ready),
        .dst_sel_i      (dst_sel),
        .sparsemap_o    (sparsemap),
        .nonzero_data_o (nonzero_data),
        .wr_valid_o     (wr_valid),
        .wr_count_o     (wr_count),
        .wr_sel_o       (wr_sel),
        .chunk_done_o   (chunk_done),
        .nz_count_o     (nz_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic build_model;
        int p;
        p = 0;
        for (int i = 0; i < MEM_SIZE; i++) exp_pk[i] = 8'h00;
        for (int k = 0; k < WR_DAT_CYC_NUM; k++) exp_map[k] = '0;
        for (int i = 0; i < MEM_SIZE; i++) begin
            if (chunk[i] != 8'h00) begin
                exp_map[i / BUS_SIZE][i % BUS_SIZE] = 1'b1;
                exp_pk[p] = chunk[i];
                p++;
            end
        end
        exp_nz = p;
    endtask

    task automatic drive_beat(input int k);
        for (int b = 0; b < BUS_SIZE; b++) dense_dat[b] = chunk[k*BUS_SIZE + b];
    endtask

    // dst_sel is toggled on later beats to confirm only the first accepted beat samples it
    task automatic feed(input logic sel, input int gap_pct, input string name);
        for (int k = 0; k < WR_DAT_CYC_NUM; k++) begin
            for (int g = 0; g < 4 && $urandom_range(99) < gap_pct; g++) begin
                dense_valid = 1'b0;
                dst_sel     = ~sel;
                tick();
            end
            chk($sformatf("%s.in_ready%0d", name, k), dense_ready, 1'b1);
            dense_valid = 1'b1;
            dst_sel     = (k == 0) ? sel : ~sel;
            drive_beat(k);
            tick();
            if (k != WR_DAT_CYC_NUM - 1)
                chk($sformatf("%s.no_early_wr%0d", name, k), wr_valid, 1'b0);
        end
        dense_valid = 1'b0;
        dense_dat   = '0;
    endtask

    // junk offered while emitting must be ignored
    task automatic check_emit(input logic sel, input string name);
        lane_t e;
        for (int k = 0; k < WR_DAT_CYC_NUM; k++) begin
            for (int b = 0; b < BUS_SIZE; b++) e[b] = exp_pk[k*BUS_SIZE + b];
            chk($sformatf("%s.vld%0d", name, k),   wr_valid, 1'b1);
            chk($sformatf("%s.cnt%0d", name, k),   wr_count, k);
            chk($sformatf("%s.map%0d", name, k),   sparsemap, exp_map[k]);
            chk($sformatf("%s.dat%0d", name, k),   nonzero_data, e);
            chk($sformatf("%s.done%0d", name, k),  chunk_done, (k == WR_DAT_CYC_NUM - 1));
            chk($sformatf("%s.sel%0d", name, k),   wr_sel, sel);
            chk($sformatf("%s.nz%0d", name, k),    nz_count, exp_nz);
            chk($sformatf("%s.rdy%0d", name, k),   dense_ready, 1'b0);
            dense_valid = (k < WR_DAT_CYC_NUM - 1);
            dense_dat   = {BUS_SIZE{8'hEE}};
            tick();
        end
        dense_valid = 1'b0;
        dense_dat   = '0;
        chk({name, ".end_vld"},  wr_valid, 1'b0);
        chk({name, ".end_cnt"},  wr_count, 0);
        chk({name, ".end_done"}, chunk_done, 1'b0);
        chk({name, ".end_rdy"},  dense_ready, 1'b1);
        chk({name, ".end_nz"},   nz_count, 0);
    endtask

    initial begin
        rst         = 1'b1;
        dense_valid = 1'b0;
        dense_dat   = '0;
        dst_sel     = 1'b0;
        #12;
        chk("rst.rdy",  dense_ready, 1'b1);
        chk("rst.vld",  wr_valid, 1'b0);
        chk("rst.cnt",  wr_count, 0);
        chk("rst.sel",  wr_sel, 1'b0);
        chk("rst.done", chunk_done, 1'b0);
        chk("rst.map",  sparsemap, 0);
        chk("rst.dat",  nonzero_data, 0);
        chk("rst.nz",   nz_count, 0);
        @(negedge clk) rst = 1'b0;
        tick();

        // all-zero chunk into buffer 1
        for (int i = 0; i < MEM_SIZE; i++) chunk[i] = 8'h00;
        build_model();
        feed(1'b1, 0, "zero");
        check_emit(1'b1, "zero");

        // no zeros: 01, FF, EF, ... 1F
        for (int i = 0; i < MEM_SIZE; i++) chunk[i] = (i == 0) ? 8'h01 : 8'(8'hFF - 16*(i-1));
        build_model();
        feed(1'b0, 0, "dense");
        chk("dense.nz_live", nz_count, MEM_SIZE);
        check_emit(1'b0, "dense");

        // single A5 at the last position
        for (int i = 0; i < MEM_SIZE; i++) chunk[i] = 8'h00;
        chunk[MEM_SIZE-1] = 8'hA5;
        build_model();
        feed(1'b1, 30, "single");
        check_emit(1'b1, "single");

        // ~30% zeros with valid gaps, then an all-zero chunk
        for (int i = 0; i < MEM_SIZE; i++)
            chunk[i] = ($urandom_range(99) < 30) ? 8'h00 : 8'($urandom_range(255, 1));
        build_model();
        feed(1'b1, 40, "rand");
        check_emit(1'b1, "rand");
        for (int i = 0; i < MEM_SIZE; i++) chunk[i] = 8'h00;
        build_model();
        feed(1'b0, 20, "zero2");
        check_emit(1'b0, "zero2");

        // reset after half a chunk
        for (int i = 0; i < MEM_SIZE; i++) chunk[i] = 8'h77;
        dst_sel = 1'b1;
        for (int k = 0; k < WR_DAT_CYC_NUM / 2; k++) begin
            dense_valid = 1'b1;
            drive_beat(k);
            tick();
        end
        dense_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstc.nz",  nz_count, 0);
        chk("rstc.sel", wr_sel, 1'b0);
        chk("rstc.vld", wr_valid, 1'b0);
        @(negedge clk) rst = 1'b0;
        tick();
        for (int i = 0; i < MEM_SIZE; i++) chunk[i] = (i % 3 == 0) ? 8'h00 : 8'(8'h10 + i);
        build_model();
        feed(1'b0, 0, "post_rst");
        check_emit(1'b0, "post_rst");

        // reset in the middle of the write burst
        for (int i = 0; i < MEM_SIZE; i++) chunk[i] = 8'(8'h30 + i);
        build_model();
        feed(1'b1, 0, "emit_rst");
        tick();
        chk("emit_rst.cnt1", wr_count, 1);
        chk("emit_rst.vld1", wr_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("emit_rst.vld",  wr_valid, 1'b0);
        chk("emit_rst.nz",   nz_count, 0);
        chk("emit_rst.cnt",  wr_count, 0);
        chk("emit_rst.done", chunk_done, 1'b0);
        @(negedge clk) rst = 1'b0;
        tick();
        chk("emit_rst.rdy",  dense_ready, 1'b1);
        chk("emit_rst.idle", wr_valid, 1'b0);

        // recovery chunk
        for (int i = 0; i < MEM_SIZE; i++) chunk[i] = (i < 2) ? 8'h5A : 8'h00;
        build_model();
        feed(1'b1, 0, "recover");
        check_emit(1'b1, "recover");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
